// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the FP8 <-> FP16 conversion paths.
package fp_pkg;

  typedef enum logic {
    FMT_E5M2 = 1'b0,
    FMT_E4M3 = 1'b1
  } fp8_fmt_e;

  localparam int FP16_BIAS = 15;
  localparam int E5M2_BIAS = 15;
  localparam int E4M3_BIAS = 7;

  // Canonical quiet NaN magnitude (sign bit supplied separately).
  localparam logic [14:0] FP16_QNAN = 15'h7E00;

  // One accepted input word, held while its beats drain.
  typedef struct packed {
    logic [31:0] word;
    fp8_fmt_e    fmt;
    logic        last;
  } hold_t;

endpackage

// File: rtl/fp8_to_fp16_unpacker_if.sv
// Valid/ready stream bundle for the FP8 -> FP16 unpacker: packed FP8 words in,
// FP16 beats out. master = the surrounding logic, slave = the unpacker.
interface fp8_to_fp16_unpacker_if #(
  parameter int OUT_LANES = 2
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic [31:0]               in_data;
  logic                      in_fmt;
  logic                      in_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [16*OUT_LANES-1:0]   out_data;
  logic                      out_last;

  modport master (
    output in_valid, in_data, in_fmt, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_fmt, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/fp8_to_fp16.sv
// Single-lane exact FP8 (E5M2 or E4M3) to FP16 widening converter.
module fp8_to_fp16
  import fp_pkg::*;
(
  input  logic [7:0]  code,
  input  fp8_fmt_e    fmt,
  output logic [15:0] result
);

  localparam logic [4:0] E5M2_REBIAS = 5'(FP16_BIAS - E5M2_BIAS);
  localparam logic [4:0] E4M3_REBIAS = 5'(FP16_BIAS - E4M3_BIAS);

  logic       sign;
  logic [3:0] e4;
  logic [2:0] m3;

  assign sign = code[7];
  assign e4   = code[6:3];
  assign m3   = code[2:0];

  // Widen one code; E4M3 subnormals are normalised since FP16 has the range.
  always_comb begin
    // NOTE: result gets a default before any branch so no path can infer a latch.
    result = '0;
    if (fmt == FMT_E5M2) begin
      // Same bias: Inf, NaN and subnormals map through with zero-padded mantissa.
      result = {sign, code[6:2] + E5M2_REBIAS, code[1:0], 8'b0};
    end else if (e4 == 4'hF && m3 == 3'h7) begin
      result = {sign, FP16_QNAN};
    end else if (e4 != 4'h0) begin
      result = {sign, {1'b0, e4} + E4M3_REBIAS, m3, 7'b0};
    end else begin
      casez (m3)
        3'b1??:  result = {sign, 5'd8, m3[1:0], 8'b0};
        3'b01?:  result = {sign, 5'd7, m3[0], 9'b0};
        3'b001:  result = {sign, 5'd6, 10'b0};
        default: result = {sign, 15'h0};
      endcase
    end
  end

endmodule

// File: rtl/fp8_to_fp16_unpacker.sv
// Streaming FP8 -> FP16 widener: holds one packed word of four FP8 values and
// emits it as 4/OUT_LANES beats of OUT_LANES FP16 values each.
module fp8_to_fp16_unpacker
  import fp_pkg::*;
#(
  parameter int OUT_LANES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fp8_to_fp16_unpacker_if.slave  bus
);

  localparam int BEATS = 4 / OUT_LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [BW-1:0]           beat_q, beat_d;
  hold_t                   hold_q;
  logic                    load;
  logic                    at_last;
  logic                    in_fire;
  logic                    out_fire;
  logic [15:0]             conv [4];
  logic [16*OUT_LANES-1:0] out_data;

  assign at_last       = (beat_q == LAST_BEAT);
  assign bus.out_valid = (state_q == DRAIN);
  // A new word may enter on the same edge that the last beat leaves.
  assign bus.in_ready  = (state_q == EMPTY) ||
                         (state_q == DRAIN && at_last && bus.out_ready);
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;
  assign bus.out_last  = hold_q.last && at_last;

  // Next-state logic: advance beats on output transfers, reload on input transfers.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    load    = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = DRAIN;
          beat_d  = '0;
          load    = 1'b1;
        end
      end
      DRAIN: begin
        if (out_fire) begin
          if (!at_last) begin
            beat_d = beat_q + 1'b1;
          end else if (in_fire) begin
            beat_d = '0;
            load   = 1'b1;
          end else begin
            state_d = EMPTY;
            beat_d  = '0;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State, beat counter and holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the holding register is reset too, so a word caught mid-drain is
    // discarded and out_data reads as converted zeros straight out of reset.
    if (!rst_n) begin
      state_q <= EMPTY;
      beat_q  <= '0;
      hold_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      beat_q  <= beat_d;
      if (load) begin
        hold_q <= '{word: bus.in_data, fmt: fp8_fmt_e'(bus.in_fmt), last: bus.in_last};
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    fp8_to_fp16 u_cvt (
      .code   (hold_q.word[8*g +: 8]),
      .fmt    (hold_q.fmt),
      .result (conv[g])
    );
  end

  // Select the converted lanes belonging to the current beat.
  always_comb begin
    out_data = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      out_data[16*j +: 16] = conv[2'(int'(beat_q) * OUT_LANES + j)];
    end
  end

  assign bus.out_data = out_data;

endmodule

// File: doc/fp8_to_fp16_unpacker.md
# fp8_to_fp16_unpacker

- Streaming widener: accepts packed words of four FP8 values (E5M2 or E4M3, selected per word) and emits them as FP16 values, OUT_LANES values per output beat, over a valid/ready handshake.
- Sits between the FP8 weight/activation buffers and the FP16 MAC array. It is the inverse path of the FP16→FP8 narrowing converters.
- Every conversion is exact; no rounding is involved.

## Interface
- OUT_LANES, default 2: FP16 values per output beat. Legal values are 1, 2, 4. Beats per input word, BEATS, equals 4/OUT_LANES.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  unpacker accepts the word this cycle.
- in_data  input  32  four FP8 lanes; lane i = in_data[8i+7:8i].
- in_fmt  input  1  0 = E5M2, 1 = E4M3 (OCP FN: no Inf, S.1111.111 = NaN).
- in_last  input  1  end-of-tensor marker for this word.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  16*OUT_LANES  FP16 lanes; lane j = out_data[16j+15:16j].
- out_last  output  1  high on the final beat of a word accepted with in_last=1.

## Operation
**State:**
- Holding register: word, fmt, last.
- Beat counter: beat, width clog2(BEATS), minimum 1 bit.
- FSM with two states, EMPTY and DRAIN.

**Handshake:**
- Transfer occurs when valid && ready.
- in_ready = (state==EMPTY) || (state==DRAIN && beat==BEATS-1 && out_ready).
- out_valid = (state==DRAIN).

**FSM transitions:**
- EMPTY, input transfer → DRAIN, beat=0, load holding register.
- DRAIN, output transfer, beat<BEATS-1 → beat+1.
- DRAIN, output transfer, beat==BEATS-1:
  - with a simultaneous input transfer → stay in DRAIN, beat=0, load the new word.
  - otherwise → EMPTY.
- DRAIN, no output transfer → hold everything.

**Output lane mapping:**
- out_data lane j = convert(held lane beat*OUT_LANES+j, fmt).
- Conversion is combinational from registered state. out_data is stable while out_valid && !out_ready.
- out_last = held last && beat==BEATS-1.

**E5M2 conversion:**
- Result is {s, e[4:0], m[1:0], 8'b0}.
- Inf, NaN and subnormals carry over unchanged (shared bias 15).

**E4M3 conversion** (s, e[3:0], m[2:0]):
- e=15, m=7 → {s, 15'h7E00} (canonical quiet NaN, sign kept).
- e in 1..15, otherwise → {s, e+5'd8, m, 7'b0}.
- e=0, m=0 → {s, 15'h0}.
- e=0, m=1xx → {s, 5'd8, m[1:0], 8'b0}.
- e=0, m=01x → {s, 5'd7, m[0], 9'b0}.
- e=0, m=001 → {s, 5'd6, 10'b0}.

**Reset mid-operation:** the held word is discarded and never emitted.

## Timing
- **Reset values:**
  - state=EMPTY, beat=0, holding register=0.
  - Outputs: out_valid=0, out_last=0, out_data=0, in_ready=1 (out_data=0 because a zero word converts to zeros).
- **Latency:** word accepted at edge N → first beat valid in cycle N+1. Beat k is valid in cycle N+1+k when out_ready stays high.
- **Throughput:** one word per BEATS cycles. Output has no bubbles with in_valid held high and out_ready high.
- **Ready dependency:** in_ready depends combinationally on out_ready, so this path is the only combinational path through the block. out_valid does not depend on in_valid.

## Structure
- **fp_pkg (shared package):**
  - fp8_fmt_e with FMT_E5M2=1'b0, FMT_E4M3=1'b1.
  - Constants: FP16_BIAS=15, E5M2_BIAS=15, E4M3_BIAS=7, FP16_QNAN=15'h7E00.
- **Sub-module fp8_to_fp16:** combinational single-lane converter (8-bit in, fmt, 16-bit out), instantiated 4 times. Compute all 4 lanes, then mux by beat.
- **Top level:** FSM, holding register, beat counter, lane mux.

## Test plan
- E5M2, OUT_LANES=2, in_data=0x3C7C8001, out_ready=1 → beat0 0x80000100, beat1 0x3C007C00.
- E4M3, OUT_LANES=4:
  - in_data=0xFF7E3801 → single beat 0xFE005F003C001800.
  - in_data=0x807F0304 → 0x80007E001E002000.
- Backpressure: out_ready=0 for 3 cycles after the first beat → out_data, out_valid=1 and in_ready=0 held unchanged. Resume → remaining beat follows.
- Back-to-back: OUT_LANES=2, in_valid=1, out_ready=1, 4 words, last with in_last=1 → a word is accepted every 2 cycles and 8 contiguous beats are emitted. out_last is high only on beat 8.
- Reset after beat0 of a word, rst_n low mid-cycle → out_valid drops immediately without waiting for clk, and in_ready=1 after release. Beat1 is never emitted; the next word starts at beat0.
- Exhaustive: all 256 codes × both formats, OUT_LANES=1 → each output matches the reference model's exact value (bit-exact, NaN canonical).
